// File: rtl/mem_ctrl_defs.sv
// Shared definitions for the memory access sequencer: one-hot state indices,
// access-type constants, the registered output bundle and its state decoder.
package mem_ctrl_defs;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_LOAD_MAR   = 4'd1,
        S_WR_LATCH   = 4'd2,
        S_MEM_WR     = 4'd3,
        S_MEM_RD     = 4'd4,
        S_RD_CAPTURE = 4'd5,
        S_RD_DRIVE   = 4'd6,
        S_DONE       = 4'd7,
        S_ERR        = 4'd8
    } state_idx_e;

    localparam int unsigned NUM_STATES = 9;

    typedef logic [NUM_STATES-1:0] state_vec_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam int unsigned DEFAULT_TIMEOUT = 16;

    typedef struct packed {
        logic marLoad;
        logic mdrWriteEn;
        logic mdrReadEn;
        logic mdrOutEn;
        logic memRead;
        logic memWrite;
        logic busy;
        logic done;
        logic err;
    } ctrl_out_t;

    function automatic state_vec_t onehot(input state_idx_e idx);
        state_vec_t v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // memRead spans MEM_RD and RD_CAPTURE so read data stays valid while MDR captures it.
    function automatic ctrl_out_t decode_outputs(input state_vec_t s);
        ctrl_out_t o;
        o            = '0;
        o.marLoad    = s[S_LOAD_MAR];
        o.mdrWriteEn = s[S_WR_LATCH];
        o.mdrReadEn  = s[S_RD_CAPTURE];
        o.mdrOutEn   = s[S_RD_DRIVE];
        o.memRead    = s[S_MEM_RD] | s[S_RD_CAPTURE];
        o.memWrite   = s[S_MEM_WR];
        o.busy       = ~s[S_IDLE];
        o.done       = s[S_DONE];
        o.err        = s[S_ERR];
        return o;
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Wait-state counter for the memory handshake; expired marks the last
// permitted cycle of an access. Saturates instead of wrapping.
module wait_timer
    import mem_ctrl_defs::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned   W    = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0]  LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != LAST)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// MAR/MDR/memory access sequencer: turns a read or write request into a series
// of registered, glitch-free strobes with a bounded memory handshake.
module mem_access_ctrl
    import mem_ctrl_defs::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic rw,
    input  logic memReady,
    output logic marLoad,
    output logic mdrWriteEn,
    output logic mdrReadEn,
    output logic mdrOutEn,
    output logic memRead,
    output logic memWrite,
    output logic busy,
    output logic done,
    output logic err
);

    state_vec_t state_q;
    state_vec_t state_d;
    logic       rw_q;
    logic       rw_d;
    ctrl_out_t  out_q;
    ctrl_out_t  out_d;

    logic in_mem;
    logic timer_clr;
    logic timer_en;
    logic timer_expired;
    logic timeout;

    // Holding the timer clear outside MEM_* guarantees a zero count on entry.
    assign in_mem    = state_q[S_MEM_RD] | state_q[S_MEM_WR];
    assign timer_clr = ~in_mem;
    assign timer_en  = in_mem & ~memReady;
    assign timeout   = timer_expired & ~memReady;

    wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (timer_clr),
        .en     (timer_en),
        .expired(timer_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= onehot(S_IDLE);
            rw_q    <= RW_READ;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = onehot(S_IDLE);
        rw_d    = rw_q;
        case (1'b1)
            state_q[S_IDLE]: begin
                if (start) begin
                    state_d = onehot(S_LOAD_MAR);
                    rw_d    = rw;
                end
            end
            state_q[S_LOAD_MAR]: begin
                if (rw_q == RW_WRITE) begin
                    state_d = onehot(S_WR_LATCH);
                end else begin
                    state_d = onehot(S_MEM_RD);
                end
            end
            state_q[S_WR_LATCH]: state_d = onehot(S_MEM_WR);
            state_q[S_MEM_WR]: begin
                if (memReady) begin
                    state_d = onehot(S_DONE);
                end else if (timeout) begin
                    state_d = onehot(S_ERR);
                end else begin
                    state_d = onehot(S_MEM_WR);
                end
            end
            state_q[S_MEM_RD]: begin
                if (memReady) begin
                    state_d = onehot(S_RD_CAPTURE);
                end else if (timeout) begin
                    state_d = onehot(S_ERR);
                end else begin
                    state_d = onehot(S_MEM_RD);
                end
            end
            state_q[S_RD_CAPTURE]: state_d = onehot(S_RD_DRIVE);
            state_q[S_RD_DRIVE]:   state_d = onehot(S_DONE);
            default:               state_d = onehot(S_IDLE);
        endcase
    end

    // Outputs decode the next state so every strobe leaves a flop directly.
    always_comb begin
        out_d = decode_outputs(state_d);
    end

    assign marLoad    = out_q.marLoad;
    assign mdrWriteEn = out_q.mdrWriteEn;
    assign mdrReadEn  = out_q.mdrReadEn;
    assign mdrOutEn   = out_q.mdrOutEn;
    assign memRead    = out_q.memRead;
    assign memWrite   = out_q.memWrite;
    assign busy       = out_q.busy;
    assign done       = out_q.done;
    assign err        = out_q.err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: each request expands into its expected
// per-cycle strobe trace; a monitor compares the DUT against it cycle by cycle.
module tb_mem_access_ctrl;

    localparam int TO = 4;

    localparam logic [8:0] MAR = 9'h100;
    localparam logic [8:0] WEN = 9'h080;
    localparam logic [8:0] REN = 9'h040;
    localparam logic [8:0] OEN = 9'h020;
    localparam logic [8:0] MRD = 9'h010;
    localparam logic [8:0] MWR = 9'h008;
    localparam logic [8:0] BSY = 9'h004;
    localparam logic [8:0] DN  = 9'h002;
    localparam logic [8:0] ER  = 9'h001;

    logic clk = 1'b0;
    logic reset, start, rw, memReady;
    logic marLoad, mdrWriteEn, mdrReadEn, mdrOutEn, memRead, memWrite, busy, done, err;
    logic [8:0] outs;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rw        (rw),
        .memReady  (memReady),
        .marLoad   (marLoad),
        .mdrWriteEn(mdrWriteEn),
        .mdrReadEn (mdrReadEn),
        .mdrOutEn  (mdrOutEn),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    assign outs = {marLoad, mdrWriteEn, mdrReadEn, mdrOutEn, memRead, memWrite, busy, done, err};

    // Behavioural MDR and memory data source.
    logic [15:0] bus_wr, mem_data, mdr_wr, mdr_rd, bus;
    always @(posedge mdrWriteEn) mdr_wr <= bus_wr;
    always @(posedge mdrReadEn)  mdr_rd <= mem_data;
    assign bus = mdrOutEn ? mdr_rd : 16'h0000;

    typedef struct {
        int unsigned cyc;
        logic [8:0]  v;
        logic        chk_wr;
        logic        chk_rd;
        logic [15:0] d;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    logic [15:0] last_rd = 16'h0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                checks++;
                if (e.cyc != cyc) begin
                    errors++;
                    $display("FAIL stale expected cyc=%0d now=%0d", e.cyc, cyc);
                end else if (outs !== e.v) begin
                    errors++;
                    $display("FAIL trace cyc=%0d got=%b want=%b", cyc, outs, e.v);
                end
                if (e.chk_wr) chk("mdr_write_reg", mdr_wr, e.d);
                if (e.chk_rd) chk("mdr_read_reg", mdr_rd, e.d);
                if (e.chk_rd && ((e.v & OEN) != 9'h0)) chk("bus_drive", bus, e.d);
            end
        end
    end

    task automatic step(input logic s, input logic r, input logic rdy, input exp_t e);
        exp_t t;
        t     = e;
        t.cyc = cyc + 1;
        start    = s;
        rw       = r;
        memReady = rdy;
        q.push_back(t);
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic idle();
        exp_t z;
        z = '{0, 9'h000, 1'b0, 1'b0, 16'h0000};
        step(1'b0, rnd(), rnd(), z);
    endtask

    // w = number of cycles memReady stays low in MEM_*; w >= TO means the access times out.
    task automatic run_txn(input logic r, input int w, input logic hold, input logic [15:0] data);
        exp_t tr[$];
        exp_t z;
        exp_t nxt;
        int   n_mem, m0;
        logic ok, rdy, s;
        z  = '{0, 9'h000, 1'b0, 1'b0, 16'h0000};
        ok = (w < TO);
        if (r) bus_wr = data;
        else   mem_data = data;
        tr.push_back('{0, MAR | BSY, 1'b0, 1'b0, 16'h0000});
        if (r) tr.push_back('{0, WEN | BSY, 1'b0, 1'b0, 16'h0000});
        m0    = tr.size();
        n_mem = ok ? w + 1 : TO;
        for (int i = 0; i < n_mem; i++)
            tr.push_back('{0, (r ? MWR : MRD) | BSY, 1'b0, 1'b0, 16'h0000});
        if (ok && !r) begin
            tr.push_back('{0, MRD | REN | BSY, 1'b0, 1'b0, 16'h0000});
            tr.push_back('{0, OEN | BSY, 1'b0, 1'b1, data});
        end
        tr.push_back('{0, (ok ? DN : ER) | BSY, r, (!r && !ok), (r ? data : last_rd)});

        step(1'b1, r, rnd(), tr[0]);
        for (int k = 0; k < tr.size(); k++) begin
            if (k >= m0 && k < m0 + n_mem) rdy = (k - m0 == w);
            else                           rdy = rnd();
            s = (k == tr.size() - 1) ? hold : rnd();
            if (k + 1 < tr.size()) nxt = tr[k + 1];
            else                   nxt = z;
            step(s, rnd(), rdy, nxt);
        end
        if (ok && !r) last_rd = data;
    endtask

    task automatic reset_mid_read();
        step(1'b1, 1'b0, 1'b0, '{0, MAR | BSY, 1'b0, 1'b0, 16'h0000});
        step(1'b0, 1'b0, 1'b0, '{0, MRD | BSY, 1'b0, 1'b0, 16'h0000});
        chk("memRead_before_reset", 16'(memRead), 16'h0001);
        #2;
        reset = 1'b1;
        q.delete();
        #1;
        chk("async_reset_outputs", 16'(outs), 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("post_reset_outputs", 16'(outs), 16'h0000);
    endtask

    initial begin : stimulus
        reset    = 1'b1;
        start    = 1'b0;
        rw       = 1'b0;
        memReady = 1'b0;
        bus_wr   = 16'h0000;
        mem_data = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 16'(outs), 16'h0000);
        reset = 1'b0;
        idle();
        idle();

        run_txn(1'b1, 0, 1'b0, 16'hA5C3);
        idle();
        run_txn(1'b0, 3, 1'b0, 16'h1234);
        idle();
        reset_mid_read();
        idle();
        run_txn(1'b0, 20, 1'b0, 16'hBEEF);
        run_txn(1'b0, 0, 1'b0, 16'h0F0F);
        run_txn(1'b1, TO - 1, 1'b0, 16'h5A5A);
        run_txn(1'b1, TO, 1'b0, 16'hC001);
        idle();
        run_txn(1'b0, 1, 1'b1, 16'h7777);
        run_txn(1'b1, 0, 1'b0, 16'h8888);

        for (int n = 0; n < 60; n++) begin
            logic h;
            h = ($urandom_range(0, 3) == 0);
            run_txn(rnd(), $urandom_range(0, TO + 2), h, 16'($urandom));
            if (!h) repeat ($urandom_range(0, 2)) idle();
        end

        idle();
        idle();
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 16'(q.size()), 16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
